// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage widths, the ID/EX control bundle, the bubble
// constant and a saturating counter helper. The forwarding unit and the EX/MEM
// stage use the same definitions.
package pipe_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 3;
  localparam int ALUOP_W = 4;

  // Control bundle that travels with an instruction from ID into EX.
  typedef struct packed {
    logic               valid;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic [ALUOP_W-1:0] aluOp;
  } idex_ctrl_t;

  // A bubble never writes, never touches memory and is never valid.
  localparam idex_ctrl_t IDEX_BUBBLE = '{
    valid:    1'b0,
    regWrite: 1'b0,
    memRead:  1'b0,
    memWrite: 1'b0,
    aluOp:    {ALUOP_W{1'b0}}
  };

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] cnt);
    if (cnt == 16'hFFFF) begin
      return cnt;
    end else begin
      return cnt + 16'd1;
    end
  endfunction

endpackage

// File: rtl/ld_use_detect.sv
// Load-use hazard compare. Purely combinational.
// Raises loadUse when the real instruction in ID reads (Rs or Rt) the register
// that the valid load currently in EX is about to write.
// Ports:
//   validId, RsId, RtId, readRsId, readRtId : instruction sitting in ID
//   validIdEx, memReadIdEx, RdIdEx          : instruction sitting in EX
//   loadUse                                 : hazard indication
module ld_use_detect #(
  parameter int REG_W = 3
) (
  input  logic             validId,
  input  logic [REG_W-1:0] RsId,
  input  logic [REG_W-1:0] RtId,
  input  logic             readRsId,
  input  logic             readRtId,
  input  logic             validIdEx,
  input  logic             memReadIdEx,
  input  logic [REG_W-1:0] RdIdEx,
  output logic             loadUse
);

  logic rsHit_s;
  logic rtHit_s;

  // A store whose Rt is the load target also hits here; it is treated like any reader.
  assign rsHit_s = readRsId & (RsId == RdIdEx);
  assign rtHit_s = readRtId & (RtId == RdIdEx);

  assign loadUse = validId & validIdEx & memReadIdEx & (rsHit_s | rtHit_s);

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, memory
// freeze and saturating stall/flush event counters.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   validId .. pcIncId         : decoded instruction and operands from ID
//   flushEx                    : taken branch/jump resolved in EX, kill ID/EX input
//   freeze                     : memory-stage stall, every register holds
//   *IdEx                      : registered instruction presented to EX
//   stallIfId                  : combinational, hold PC and IF/ID this cycle
//   stallCount, flushCount     : saturating 16-bit event counters
// Next-state priority: reset > freeze > flushEx > loadUse > normal load.
module id_ex_pipe #(
  parameter int DATA_W  = pipe_pkg::DATA_W,
  parameter int REG_W   = pipe_pkg::REG_W,
  parameter int ALUOP_W = pipe_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               validId,
  input  logic [REG_W-1:0]   RsId,
  input  logic [REG_W-1:0]   RtId,
  input  logic [REG_W-1:0]   RdId,
  input  logic               readRsId,
  input  logic               readRtId,
  input  logic               RegWriteId,
  input  logic               MemReadId,
  input  logic               MemWriteId,
  input  logic [ALUOP_W-1:0] aluOpId,
  input  logic [DATA_W-1:0]  rsDataId,
  input  logic [DATA_W-1:0]  rtDataId,
  input  logic [DATA_W-1:0]  immId,
  input  logic [DATA_W-1:0]  pcIncId,
  input  logic               flushEx,
  input  logic               freeze,
  output logic               validIdEx,
  output logic               RegWriteIdEx,
  output logic               MemReadIdEx,
  output logic               MemWriteIdEx,
  output logic [REG_W-1:0]   RsIdEx,
  output logic [REG_W-1:0]   RtIdEx,
  output logic [REG_W-1:0]   RdIdEx,
  output logic [ALUOP_W-1:0] aluOpIdEx,
  output logic [DATA_W-1:0]  rsDataIdEx,
  output logic [DATA_W-1:0]  rtDataIdEx,
  output logic [DATA_W-1:0]  immIdEx,
  output logic [DATA_W-1:0]  pcIncIdEx,
  output logic               stallIfId,
  output logic [15:0]        stallCount,
  output logic [15:0]        flushCount
);

  import pipe_pkg::*;

  idex_ctrl_t         ctrlId_s;
  idex_ctrl_t         ctrl_r;
  logic               loadUse_s;
  logic               takeFlush_s;
  logic               takeStall_s;
  logic [REG_W-1:0]   rs_r;
  logic [REG_W-1:0]   rt_r;
  logic [REG_W-1:0]   rd_r;
  logic [DATA_W-1:0]  rsData_r;
  logic [DATA_W-1:0]  rtData_r;
  logic [DATA_W-1:0]  imm_r;
  logic [DATA_W-1:0]  pcInc_r;
  logic [15:0]        stallCount_r;
  logic [15:0]        flushCount_r;

  ld_use_detect #(
    .REG_W(REG_W)
  ) uLdUse (
    .validId     (validId),
    .RsId        (RsId),
    .RtId        (RtId),
    .readRsId    (readRsId),
    .readRtId    (readRtId),
    .validIdEx   (ctrl_r.valid),
    .memReadIdEx (ctrl_r.memRead),
    .RdIdEx      (rd_r),
    .loadUse     (loadUse_s)
  );

  // Decide this cycle's event and form the control bundle offered by ID.
  always_comb begin
    ctrlId_s    = IDEX_BUBBLE;
    // Freeze already holds the front end, so neither event is taken under it;
    // a flush outranks the hazard because the IF/ID instruction is being killed.
    takeFlush_s = ~freeze & flushEx;
    takeStall_s = ~freeze & ~flushEx & loadUse_s;
    // An invalid ID slot carries no control at all, so RegWriteIdEx implies validIdEx.
    if (validId) begin
      ctrlId_s.valid    = 1'b1;
      ctrlId_s.regWrite = RegWriteId;
      ctrlId_s.memRead  = MemReadId;
      ctrlId_s.memWrite = MemWriteId;
      ctrlId_s.aluOp    = aluOpId;
    end else begin
      ctrlId_s = IDEX_BUBBLE;
    end
  end

  // ID/EX pipeline register: hold on freeze, bubble on flush/hazard, else capture ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r   <= IDEX_BUBBLE;
      rs_r     <= {REG_W{1'b0}};
      rt_r     <= {REG_W{1'b0}};
      rd_r     <= {REG_W{1'b0}};
      rsData_r <= {DATA_W{1'b0}};
      rtData_r <= {DATA_W{1'b0}};
      imm_r    <= {DATA_W{1'b0}};
      pcInc_r  <= {DATA_W{1'b0}};
    end else if (freeze) begin
      ctrl_r   <= ctrl_r;
      rs_r     <= rs_r;
      rt_r     <= rt_r;
      rd_r     <= rd_r;
      rsData_r <= rsData_r;
      rtData_r <= rtData_r;
      imm_r    <= imm_r;
      pcInc_r  <= pcInc_r;
    end else begin
      // Data always follows ID; inside a bubble it is don't-care but deterministic.
      rsData_r <= rsDataId;
      rtData_r <= rtDataId;
      imm_r    <= immId;
      pcInc_r  <= pcIncId;
      if (takeFlush_s || takeStall_s) begin
        ctrl_r <= IDEX_BUBBLE;
        rs_r   <= {REG_W{1'b0}};
        rt_r   <= {REG_W{1'b0}};
        rd_r   <= {REG_W{1'b0}};
      end else begin
        ctrl_r <= ctrlId_s;
        rs_r   <= RsId;
        rt_r   <= RtId;
        rd_r   <= RdId;
      end
    end
  end

  // Saturating event counters; a frozen cycle never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount_r <= 16'h0000;
      flushCount_r <= 16'h0000;
    end else if (takeFlush_s) begin
      stallCount_r <= stallCount_r;
      flushCount_r <= satInc(flushCount_r);
    end else if (takeStall_s) begin
      stallCount_r <= satInc(stallCount_r);
      flushCount_r <= flushCount_r;
    end else begin
      stallCount_r <= stallCount_r;
      flushCount_r <= flushCount_r;
    end
  end

  // The stall is combinational on purpose: the front end must hold in this very cycle.
  // Because the bubble clears MemReadIdEx, one hazard can stall at most once.
  assign stallIfId    = takeStall_s;

  assign validIdEx    = ctrl_r.valid;
  assign RegWriteIdEx = ctrl_r.regWrite;
  assign MemReadIdEx  = ctrl_r.memRead;
  assign MemWriteIdEx = ctrl_r.memWrite;
  assign aluOpIdEx    = ctrl_r.aluOp;
  assign RsIdEx       = rs_r;
  assign RtIdEx       = rt_r;
  assign RdIdEx       = rd_r;
  assign rsDataIdEx   = rsData_r;
  assign rtDataIdEx   = rtData_r;
  assign immIdEx      = imm_r;
  assign pcIncIdEx    = pcInc_r;
  assign stallCount   = stallCount_r;
  assign flushCount   = flushCount_r;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        validId = 1'b0;
  logic [2:0]  RsId = 3'd0, RtId = 3'd0, RdId = 3'd0;
  logic        readRsId = 1'b0, readRtId = 1'b0;
  logic        RegWriteId = 1'b0, MemReadId = 1'b0, MemWriteId = 1'b0;
  logic [3:0]  aluOpId = 4'd0;
  logic [15:0] rsDataId = 16'd0, rtDataId = 16'd0, immId = 16'd0, pcIncId = 16'd0;
  logic        flushEx = 1'b0, freeze = 1'b0;

  logic        validIdEx, RegWriteIdEx, MemReadIdEx, MemWriteIdEx;
  logic [2:0]  RsIdEx, RtIdEx, RdIdEx;
  logic [3:0]  aluOpIdEx;
  logic [15:0] rsDataIdEx, rtDataIdEx, immIdEx, pcIncIdEx;
  logic        stallIfId;
  logic [15:0] stallCount, flushCount;

  id_ex_pipe dut (
    .clk(clk), .rst_n(rst_n), .validId(validId),
    .RsId(RsId), .RtId(RtId), .RdId(RdId),
    .readRsId(readRsId), .readRtId(readRtId),
    .RegWriteId(RegWriteId), .MemReadId(MemReadId), .MemWriteId(MemWriteId),
    .aluOpId(aluOpId), .rsDataId(rsDataId), .rtDataId(rtDataId),
    .immId(immId), .pcIncId(pcIncId), .flushEx(flushEx), .freeze(freeze),
    .validIdEx(validIdEx), .RegWriteIdEx(RegWriteIdEx),
    .MemReadIdEx(MemReadIdEx), .MemWriteIdEx(MemWriteIdEx),
    .RsIdEx(RsIdEx), .RtIdEx(RtIdEx), .RdIdEx(RdIdEx), .aluOpIdEx(aluOpIdEx),
    .rsDataIdEx(rsDataIdEx), .rtDataIdEx(rtDataIdEx),
    .immIdEx(immIdEx), .pcIncIdEx(pcIncIdEx),
    .stallIfId(stallIfId), .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nMis = 0;

  // Model of what EX currently holds.
  bit        mValid, mRw, mMr, mMw;
  bit [3:0]  mAlu;
  bit [2:0]  mRs, mRt, mRd;
  bit [15:0] mRsD, mRtD, mImm, mPc;
  int        mStallC, mFlushC;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Does the real instruction in ID read the register the EX load will produce?
  function automatic bit modelHazard();
    if (!(validId && mValid && mMr)) return 1'b0;
    return (readRsId && RsId == mRd) || (readRtId && RtId == mRd);
  endfunction

  function automatic bit modelStall();
    return !freeze && !flushEx && modelHazard();
  endfunction

  task automatic modelReset();
    {mValid, mRw, mMr, mMw} = 4'b0;
    mAlu = 4'd0; mRs = 3'd0; mRt = 3'd0; mRd = 3'd0;
    mRsD = 16'd0; mRtD = 16'd0; mImm = 16'd0; mPc = 16'd0;
    mStallC = 0; mFlushC = 0;
  endtask

  // What one rising edge does to EX, stated from the pipeline rules.
  task automatic modelEdge();
    bit killed;
    if (!rst_n) begin
      modelReset();
    end else if (!freeze) begin
      killed = flushEx || modelHazard();
      if (flushEx) mFlushC = (mFlushC + 1 > 65535) ? 65535 : mFlushC + 1;
      else if (killed) mStallC = (mStallC + 1 > 65535) ? 65535 : mStallC + 1;
      mRsD = rsDataId; mRtD = rtDataId; mImm = immId; mPc = pcIncId;
      if (killed) begin
        {mValid, mRw, mMr, mMw} = 4'b0; mAlu = 4'd0;
        mRs = 3'd0; mRt = 3'd0; mRd = 3'd0;
      end else begin
        mValid = validId;
        mRw = validId && RegWriteId;
        mMr = validId && MemReadId;
        mMw = validId && MemWriteId;
        mAlu = validId ? aluOpId : 4'd0;
        mRs = RsId; mRt = RtId; mRd = RdId;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  // Every out-of-reset cycle: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("validIdEx", validIdEx, mValid);
      chk("RegWriteIdEx", RegWriteIdEx, mRw);
      chk("MemReadIdEx", MemReadIdEx, mMr);
      chk("MemWriteIdEx", MemWriteIdEx, mMw);
      chk("aluOpIdEx", aluOpIdEx, mAlu);
      chk("RsIdEx", RsIdEx, mRs);
      chk("RtIdEx", RtIdEx, mRt);
      chk("RdIdEx", RdIdEx, mRd);
      chk("rsDataIdEx", rsDataIdEx, mRsD);
      chk("rtDataIdEx", rtDataIdEx, mRtD);
      chk("immIdEx", immIdEx, mImm);
      chk("pcIncIdEx", pcIncIdEx, mPc);
      chk("stallIfId", stallIfId, modelStall());
      chk("stallCount", stallCount, mStallC);
      chk("flushCount", flushCount, mFlushC);
    end
  end

  task automatic idle();
    validId = 1'b0; readRsId = 1'b0; readRtId = 1'b0;
    RegWriteId = 1'b0; MemReadId = 1'b0; MemWriteId = 1'b0;
    flushEx = 1'b0; freeze = 1'b0;
  endtask

  // Load word into rd.
  task automatic setLoad(input logic [2:0] rd);
    idle();
    validId = 1'b1; MemReadId = 1'b1; RegWriteId = 1'b1;
    RsId = 3'd1; RtId = 3'd0; RdId = rd; readRsId = 1'b1; aluOpId = 4'd2;
    rsDataId = 16'h0100; immId = 16'h0004; pcIncId = 16'h0010;
  endtask

  // ALU op reading rs/rt.
  task automatic setAlu(input logic [2:0] rs, input logic rdRs,
                        input logic [2:0] rt, input logic rdRt);
    idle();
    validId = 1'b1; RegWriteId = 1'b1; aluOpId = 4'd5;
    RsId = rs; RtId = rt; RdId = 3'd6; readRsId = rdRs; readRtId = rdRt;
    rsDataId = 16'h1111; rtDataId = 16'h2222; pcIncId = 16'h0012;
  endtask

  task automatic randInputs();
    validId    = ($urandom_range(3) != 0);
    RsId       = 3'($urandom_range(3));
    RtId       = 3'($urandom_range(3));
    RdId       = 3'($urandom_range(3));
    readRsId   = ($urandom_range(3) != 0);
    readRtId   = ($urandom_range(1) != 0);
    RegWriteId = ($urandom_range(1) != 0);
    MemReadId  = ($urandom_range(1) != 0);
    MemWriteId = ($urandom_range(3) == 0);
    aluOpId    = 4'($urandom_range(15));
    rsDataId   = 16'($urandom);
    rtDataId   = 16'($urandom);
    immId      = 16'($urandom);
    pcIncId    = 16'($urandom);
    flushEx    = ($urandom_range(7) == 0);
    freeze     = ($urandom_range(7) == 0);
  endtask

  initial begin
    modelReset();
    #1;
    chk("reset validIdEx", validIdEx, 1'b0);
    chk("reset stallCount", stallCount, 16'd0);
    #12 rst_n = 1'b1;                   // released mid-cycle
    step();

    // 1: load R3, then ADD reading R3 -> exactly one stall cycle.
    setLoad(3'd3); step();
    setAlu(3'd3, 1'b1, 3'd1, 1'b1); #1;
    chk("t1 stall", stallIfId, 1'b1);
    step();
    chk("t1 bubble", validIdEx, 1'b0);
    chk("t1 stallCount", stallCount, 16'd1);
    #1 chk("t1 no restall", stallIfId, 1'b0);
    step();
    chk("t1 add valid", validIdEx, 1'b1);
    chk("t1 add Rs", RsIdEx, 3'd3);

    // 2: independent op passes with one-cycle latency.
    setLoad(3'd3); step();
    setAlu(3'd2, 1'b1, 3'd4, 1'b1); #1;
    chk("t2 stall", stallIfId, 1'b0);
    step();
    chk("t2 Rs", RsIdEx, 3'd2);
    chk("t2 rsData", rsDataIdEx, 16'h1111);

    // 3: Rt matches but is not read.
    setLoad(3'd3); step();
    setAlu(3'd1, 1'b1, 3'd3, 1'b0); #1;
    chk("t3 stall", stallIfId, 1'b0);
    step();

    // 4: flush and load-use together: flush wins.
    setLoad(3'd3); step();
    setAlu(3'd3, 1'b1, 3'd1, 1'b0); flushEx = 1'b1; #1;
    chk("t4 stall", stallIfId, 1'b0);
    step();
    chk("t4 bubble", validIdEx, 1'b0);
    chk("t4 flushCount", flushCount, 16'd1);
    chk("t4 stallCount", stallCount, 16'd1);

    // 5: freeze holds the loaded instruction; a flush pulse under freeze is lost.
    setAlu(3'd2, 1'b1, 3'd4, 1'b1); rsDataId = 16'hBEEF; step();
    rsDataId = 16'h1234; freeze = 1'b1; step();
    flushEx = 1'b1; step();
    flushEx = 1'b0; step();
    chk("t5 hold", rsDataIdEx, 16'hBEEF);
    chk("t5 valid held", validIdEx, 1'b1);
    chk("t5 flush ignored", flushCount, 16'd1);
    flushEx = 1'b1; step();
    freeze = 1'b0; step();
    chk("t5 flush on release", validIdEx, 1'b0);
    chk("t5 flushCount", flushCount, 16'd2);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      randInputs();
      step();
    end

    // 6: saturation from a preloaded 0xFFFE, then asynchronous reset mid-stall.
    idle(); step();
    force dut.stallCount_r = 16'hFFFE;
    mStallC = 16'hFFFE;
    step();
    release dut.stallCount_r;
    for (int k = 0; k < 2; k++) begin
      setLoad(3'd5); step();
      setAlu(3'd5, 1'b1, 3'd0, 1'b0); step();
      idle(); step();
    end
    chk("t6 saturated", stallCount, 16'hFFFF);
    setLoad(3'd5); step();
    setAlu(3'd0, 1'b0, 3'd5, 1'b1); #1;
    chk("t6 pre-reset stall", stallIfId, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 async stallIfId", stallIfId, 1'b0);
    chk("t6 async validIdEx", validIdEx, 1'b0);
    chk("t6 async RdIdEx", RdIdEx, 3'd0);
    chk("t6 async rsData", rsDataIdEx, 16'd0);
    chk("t6 async stallCount", stallCount, 16'd0);
    chk("t6 async flushCount", flushCount, 16'd0);
    modelReset();
    step();
    rst_n = 1'b1;
    idle(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

- Owns the ID/EX pipeline register and detects load-use hazards.
- Captures decoded fields and operands from ID and presents the registered `*IdEx` fields to EX and the forwarding unit.
- Inserts a one-cycle bubble when an instruction in ID reads a register that the load in EX will write.
- Kills the EX-bound instruction on a branch flush, freezes on a memory stall, and keeps saturating performance counters.

## Interface
Parameters:
- DATA_W, 16, operand/immediate/PC width
- REG_W, 3, register-specifier width
- ALUOP_W, 4, ALU opcode width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- validId  in  1  ID holds a real instruction
- RsId, RtId, RdId  in  REG_W  source/dest specifiers from decode
- readRsId, readRtId  in  1  instruction actually reads Rs/Rt
- RegWriteId, MemReadId, MemWriteId  in  1  decoded control
- aluOpId  in  ALUOP_W  decoded ALU op
- rsDataId, rtDataId, immId, pcIncId  in  DATA_W  register-file reads, extended immediate, PC+2
- flushEx  in  1  branch/jump resolved taken in EX
- freeze  in  1  memory-stage stall, whole pipe holds
- validIdEx, RegWriteIdEx, MemReadIdEx, MemWriteIdEx  out  1  registered control
- RsIdEx, RtIdEx, RdIdEx  out  REG_W  registered specifiers
- aluOpIdEx  out  ALUOP_W  registered ALU op
- rsDataIdEx, rtDataIdEx, immIdEx, pcIncIdEx  out  DATA_W  registered data
- stallIfId  out  1  combinational; holds PC and IF/ID this cycle
- stallCount, flushCount  out  16  saturating event counters

## Operation
**Load-use detection (combinational):**
- loadUse = validId & validIdEx & MemReadIdEx & ((readRsId & RsId==RdIdEx) | (readRtId & RtId==RdIdEx)).
- Store-after-load on Rt also stalls; no special case.

**Next-state priority, highest first:**
1. Reset: all outputs 0.
2. freeze = 1: every register holds. Counters hold. stallIfId = 0, because freeze already stalls the front end.
3. flushEx = 1: ID/EX loads the bubble. stallIfId = 0. flushCount increments.
4. loadUse = 1: ID/EX loads the bubble. stallIfId = 1. stallCount increments.
5. Otherwise: ID/EX loads all ID inputs, with validIdEx = validId.

**Bubble definition:**
- validIdEx, RegWriteIdEx, MemReadIdEx, MemWriteIdEx = 0.
- RsIdEx, RtIdEx, RdIdEx = 0. aluOpIdEx = 0.
- Data fields are loaded from ID anyway; they are don't-care, but the value is deterministic.

**Invalid ID instruction:**
- If validId = 0, control outputs load as 0 even on a normal load.
- This guarantees RegWriteIdEx implies validIdEx.

**One stall per hazard:**
- After a bubble, MemReadIdEx = 0, so the same IF/ID instruction cannot stall twice.
- The MEM/WB load-data forwarding path covers the remaining distance.

**Counters:** 16-bit and saturate at 0xFFFF; they do not wrap.

## Timing
- Latency: ID inputs appear on the `*IdEx` outputs one clock after capture.
- stallIfId is valid in the same cycle as the inputs; it has no registered delay.
- Reset is asynchronous assert; release is synchronous to clk through the standard top-level synchronizer.
- Reset mid-stall: stallIfId drops immediately, because validIdEx = 0.
- Simultaneous flushEx & loadUse: flush wins and stallIfId = 0, since the IF/ID instruction is being killed.
- Simultaneous freeze & flushEx: the flush is not taken. flushEx must remain asserted until freeze deasserts, because the branch stays in EX.

## Structure
Shared package `pipe_pkg`:
- REG_W, DATA_W, ALUOP_W.
- idex_ctrl_t (valid, RegWrite, MemRead, MemWrite, aluOp).
- IDEX_BUBBLE constant.
- The same package is used by the forwarding and EX/MEM stages.

One sub-module `ld_use_detect` holds the pure combinational hazard compare. The register, priority mux and counters live in the top.

## Test plan
1. Load then dependent ALU op: EX holds load R3 (MemReadIdEx=1, RdIdEx=3) and ID holds ADD reading RsId=3.
   - stallIfId=1 for exactly one cycle, then validIdEx=0, then ADD appears with RsIdEx=3. stallCount=1.
2. Load then independent op: RdIdEx=3, RsId=2, RtId=4.
   - stallIfId=0; instruction passes with one-cycle latency.
3. Dependent but not read: RtId=3 with readRtId=0.
   - No stall.
4. Flush and loadUse together.
   - Bubble loaded, stallIfId=0, flushCount=1, stallCount unchanged.
5. Freeze for 3 cycles with pipe loaded (rsDataIdEx=0xBEEF).
   - Outputs hold 0xBEEF. A flushEx pulse during freeze is ignored; a flush held through release takes effect on the first unfrozen edge.
6. Counter saturation and reset.
   - Preload stallCount=0xFFFE, apply two stalls: count stays 0xFFFF.
   - Assert rst_n=0 mid-cycle: all outputs 0 immediately, without waiting for an edge.
